// File: rtl/symbol_serializer.sv
// Framed serial transmitter: takes a 2-bit symbol over valid/ready and sends
// start, sym[1], sym[0], stop on bit_o, each bit held BIT_CYCLES clocks.
module symbol_serializer #(
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [1:0]       symbol_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             bit_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic [CNT_W-1:0] frames_o
);

  // state | meaning
  // IDLE  | line idle at 0, ready for a symbol
  // START | start bit (1)
  // D1    | symbol bit 1
  // D0    | symbol bit 0
  // STOP  | stop bit (0); last cycle may accept the next symbol
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    D1    = 3'd2,
    D0    = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  state_t           state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [1:0]       sym_q, sym_n;
  logic             bit_q, bit_n;
  logic             busy_q;
  logic             done_q, done_n;
  logic [CNT_W-1:0] frames_q, frames_n;
  logic             last;
  logic             hs;

  assign last    = (cnt_q == LAST);
  assign ready_o = !reset_i && ((state_q == IDLE) || ((state_q == STOP) && last));
  assign hs      = valid_i && ready_o;

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    sym_n    = hs ? symbol_i : sym_q;
    frames_n = frames_q;
    case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (hs) state_n = START;
      end
      START, D1, D0, STOP: begin
        if (last) begin
          cnt_n = '0;
          case (state_q)
            START:   state_n = D1;
            D1:      state_n = D0;
            D0:      state_n = STOP;
            default: begin
              state_n  = hs ? START : IDLE;
              frames_n = frames_q + CNT_W'(1);
            end
          endcase
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // outputs are computed from the next state so the registers line up with it
    case (state_n)
      START:   bit_n = 1'b1;
      D1:      bit_n = sym_n[1];
      D0:      bit_n = sym_n[0];
      default: bit_n = 1'b0;
    endcase
    done_n = (state_n == STOP) && (cnt_n == LAST);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sym_q    <= '0;
      bit_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      sym_q    <= sym_n;
      bit_q    <= bit_n;
      busy_q   <= (state_n != IDLE);
      done_q   <= done_n;
      frames_q <= frames_n;
    end
  end

  assign bit_o        = bit_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign frames_o     = frames_q;

endmodule

// File: tb/tb_symbol_serializer.sv
// Directed bench for symbol_serializer with three parameterisations on one clock.
module tb_symbol_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // a: BIT_CYCLES=1, CNT_W=2   b: BIT_CYCLES=2   c: BIT_CYCLES=3
  logic       ra, va, rdy_a, bit_a, busy_a, fd_a;
  logic [1:0] sa, frames_a;
  logic       rb, vb, rdy_b, bit_b, busy_b, fd_b;
  logic [1:0] sb;
  logic [7:0] frames_b;
  logic       rc, vc, rdy_c, bit_c, busy_c, fd_c;
  logic [1:0] sc;
  logic [7:0] frames_c;

  symbol_serializer #(.BIT_CYCLES(1), .CNT_W(2)) dut_a (
    .clk_i(clk), .reset_i(ra), .symbol_i(sa), .valid_i(va), .ready_o(rdy_a),
    .bit_o(bit_a), .busy_o(busy_a), .frame_done_o(fd_a), .frames_o(frames_a));

  symbol_serializer #(.BIT_CYCLES(2), .CNT_W(8)) dut_b (
    .clk_i(clk), .reset_i(rb), .symbol_i(sb), .valid_i(vb), .ready_o(rdy_b),
    .bit_o(bit_b), .busy_o(busy_b), .frame_done_o(fd_b), .frames_o(frames_b));

  symbol_serializer #(.BIT_CYCLES(3), .CNT_W(8)) dut_c (
    .clk_i(clk), .reset_i(rc), .symbol_i(sc), .valid_i(vc), .ready_o(rdy_c),
    .bit_o(bit_c), .busy_o(busy_c), .frame_done_o(fd_c), .frames_o(frames_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  e3_bit, e3_rdy, e3_frm;
  logic [11:0] e4_bit;
  logic [7:0]  e2_bit;

  initial begin
    ra = 1'b1; va = 1'b1; sa = 2'b01;
    rb = 1'b1; vb = 1'b0; sb = 2'b00;
    rc = 1'b1; vc = 1'b0; sc = 2'b00;

    // 1: reset held with valid high
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_bit",    bit_a,    0);
      chk("t1_busy",   busy_a,   0);
      chk("t1_ready",  rdy_a,    0);
      chk("t1_frames", frames_a, 0);
    end
    ra = 1'b0; rb = 1'b0; rc = 1'b0;
    #1;
    chk("t1_ready_after", rdy_a, 1);

    // 3: back-to-back 01 then 11, BIT_CYCLES=1
    e3_bit = 8'b1010_1110;
    e3_rdy = 8'b0001_0001;
    e3_frm = 8'b0000_1111;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) sa = 2'b11;
      if (i == 4) va = 1'b0;
      chk("t3_bit",    bit_a,  e3_bit[7-i]);
      chk("t3_ready",  rdy_a,  e3_rdy[7-i]);
      chk("t3_done",   fd_a,   e3_rdy[7-i]);
      chk("t3_busy",   busy_a, 1);
      chk("t3_frames", frames_a, e3_frm[7-i]);
    end
    step();
    chk("t3_frames_end", frames_a, 2);
    chk("t3_busy_end",   busy_a,   0);
    chk("t3_bit_end",    bit_a,    0);

    // 6: counter wrap with CNT_W=2
    ra = 1'b1;
    step();
    ra = 1'b0;
    chk("t6_frames_rst", frames_a, 0);
    va = 1'b1; sa = 2'b00;
    step();
    for (int k = 1; k <= 5; k++) begin
      repeat (4) step();
      chk("t6_frames", frames_a, k % 4);
      if (k == 4) va = 1'b0;
    end
    chk("t6_busy_end", busy_a, 0);

    // 5: reset during D1, BIT_CYCLES=2
    vb = 1'b1; sb = 2'b11;
    step();
    vb = 1'b0;
    step();
    step();
    chk("t5_in_d1", bit_b, 1);
    rb = 1'b1; vb = 1'b1;
    step();
    chk("t5_bit",    bit_b,    0);
    chk("t5_busy",   busy_b,   0);
    chk("t5_frames", frames_b, 0);
    chk("t5_ready_in_rst", rdy_b, 0);
    rb = 1'b0; vb = 1'b0;
    #1;
    chk("t5_ready_after", rdy_b, 1);
    step();
    chk("t5_idle", busy_b, 0);

    // 2: single frame 10, BIT_CYCLES=2
    vb = 1'b1; sb = 2'b10;
    #1;
    chk("t2_ready", rdy_b, 1);
    step();
    vb = 1'b0; sb = 2'b01;
    e2_bit = 8'b1111_0000;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      chk("t2_bit",    bit_b,    e2_bit[7-i]);
      chk("t2_done",   fd_b,     (i == 7) ? 1 : 0);
      chk("t2_frames", frames_b, 0);
    end
    step();
    chk("t2_frames_end", frames_b, 1);
    chk("t2_bit_end",    bit_b,    0);
    chk("t2_busy_end",   busy_b,   0);
    chk("t2_done_end",   fd_b,     0);

    // 4: stall with changing symbol, BIT_CYCLES=3
    vc = 1'b1; sc = 2'b01;
    step();
    sc = 2'b11;
    e4_bit = 12'b111_000_111_000;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      if (i == 5) sc = 2'b10;
      chk("t4_bit1",   bit_c, e4_bit[11-i]);
      chk("t4_ready1", rdy_c, (i == 11) ? 1 : 0);
    end
    chk("t4_done1", fd_c, 1);
    e4_bit = 12'b111_111_000_000;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) vc = 1'b0;
      if (i == 2) sc = 2'b01;
      chk("t4_bit2",   bit_c,    e4_bit[11-i]);
      chk("t4_frames", frames_c, 1);
    end
    chk("t4_done2", fd_c, 1);
    step();
    chk("t4_frames_end", frames_c, 2);
    chk("t4_busy_end",   busy_c,   0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
